// File: rtl/act_requant_pkg.sv
// Shared layer constants (nn_pkg) plus the block-local defaults for the
// activation requantiser (act_requant_pkg).
package nn_pkg;
  localparam int ACC_W     = 22;  // accumulator sum width, signed
  localparam int ACC_FRAC  = 12;  // fractional bits of the sum (Q9.12)
  localparam int ACT_W     = 8;   // activation width, unsigned
  localparam int ACT_FRAC  = 4;   // fractional bits of the activation (Q4.4)
  localparam int N_NEURONS = 10;  // neurons per layer
endpackage

package act_requant_pkg;
  import nn_pkg::*;

  localparam int DEF_FIFO_DEPTH = 4;  // output buffer entries
  localparam int DEF_IDX_W      = 4;  // neuron index width

  // Largest value representable in an unsigned activation of width w.
  function automatic int act_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/act_requant_if.sv
// Activation stream towards the next layer.
// Handshake: the master holds out_data/out_idx/out_last stable while out_valid
// is high and out_ready is low; one word transfers on each rising clock edge
// where out_valid && out_ready; out_valid never waits for out_ready.
interface act_requant_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
);
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/act_requant_sync_fifo.sv
// Small synchronous FIFO with a registered storage array. Push and pop on
// the same edge while full is legal (the head leaves as the new word lands).
// A push while full without a pop is refused; the caller decides what that means.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_pop;
  logic              do_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; clear only rewinds pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/act_requant.sv
// Requantises finished Q9.12 neuron sums to unsigned Q4.4 activations
// (ReLU, round half up, saturate), buffers them and streams them out tagged
// with a wrapping neuron index. Upstream is never stalled; a sample arriving
// at a full buffer that is not draining is dropped and flagged sticky.
module act_requant
  import nn_pkg::*;
  import act_requant_pkg::*;
#(
  parameter int IN_W       = ACC_W,
  parameter int IN_FRAC    = ACC_FRAC,
  parameter int OUT_W      = ACT_W,
  parameter int OUT_FRAC   = ACT_FRAC,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int NEURONS    = N_NEURONS,
  parameter int IDX_W      = DEF_IDX_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [IN_W-1:0] acc_in,
  input  logic            acc_valid,
  act_requant_if.master   out_if,
  output logic            overflow
);
  localparam int SH = IN_FRAC - OUT_FRAC;
  localparam logic [IN_W:0]      HALF     = (IN_W+1)'(1) << (SH - 1);
  localparam logic [IN_W:0]      SAT_WIDE = (IN_W+1)'(act_max(OUT_W));
  localparam logic [OUT_W-1:0]   SAT      = '1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NEURONS - 1);

  logic              s1_valid;
  logic [IN_W:0]     s1_r;
  logic [IN_W:0]     s1_r_next;
  logic              s2_valid;
  logic [OUT_W-1:0]  s2_act;
  logic [OUT_W-1:0]  s2_act_next;
  logic [IDX_W-1:0]  idx;
  logic              fifo_full;
  logic              fifo_empty;
  logic [OUT_W-1:0]  fifo_dout;
  logic              handshake;

  assign handshake = out_if.out_valid && out_if.out_ready;

  // ReLU then round half up; one extra bit keeps the rounding add from wrapping.
  always_comb begin
    s1_r_next = '0;
    if (!acc_in[IN_W-1]) s1_r_next = ({1'b0, acc_in} + HALF) >> SH;
  end

  // Stage 1 register: rounded, non-negative value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else begin
      s1_valid <= acc_valid;
      s1_r     <= s1_r_next;
    end
  end

  // Clamp to the largest activation code.
  always_comb begin
    s2_act_next = s1_r[OUT_W-1:0];
    if (s1_r > SAT_WIDE) s2_act_next = SAT;
  end

  // Stage 2 register: final activation waiting for the FIFO write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_act   <= '0;
    end else if (clear) begin
      s2_valid <= 1'b0;
      s2_act   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_act   <= s2_act_next;
    end
  end

  sync_fifo #(
    .DATA_W (OUT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (s2_valid),
    .pop   (handshake),
    .din   (s2_act),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Neuron index advances per delivered activation and wraps at the layer end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (handshake) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Sticky drop flag: a write found the buffer full and nothing leaving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (s2_valid && fifo_full && !handshake) begin
      overflow <= 1'b1;
    end
  end

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_dout;
  assign out_if.out_idx   = idx;
  assign out_if.out_last  = (idx == IDX_LAST);
endmodule
